// File: rtl/univ_shift_reg_if.sv
// Purpose: groups the data/control signals of the universal shift register.
// Ports:   master drives en/mode/parallel_in/serial inputs and observes outputs;
//          slave (the register itself) is the reverse.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    // Counter width: max(1, clog2(WIDTH)).
    localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_in_r;
    logic             serial_in_l;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out_r;
    logic             serial_out_l;
    logic [CW-1:0]    shift_cnt;
    logic             word_done;

    modport master (
        output en, mode, parallel_in, serial_in_r, serial_in_l,
        input  parallel_out, serial_out_r, serial_out_l, shift_cnt, word_done
    );

    modport slave (
        input  en, mode, parallel_in, serial_in_r, serial_in_l,
        output parallel_out, serial_out_r, serial_out_l, shift_cnt, word_done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Purpose: universal shift register (hold / shift right / shift left / parallel load)
//          with a per-word shift counter that pulses word_done after every WIDTH shifts.
// Latency: one clk edge from inputs to q; serial/parallel outputs are wires from q.
// Backpressure: none; en=0 freezes q and shift_cnt and suppresses word_done.
// Ports:   clk, rst (synchronous active-high); bus (slave modport) carries en, mode,
//          parallel_in, serial_in_r/l, parallel_out, serial_out_r/l, shift_cnt, word_done.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    univ_shift_reg_if.slave    bus
);
    localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q,    q_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             done_q, done_d;

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: begin
                    q_d = q_q;
                end
                MODE_RIGHT: begin
                    q_d = {bus.serial_in_r, q_q[WIDTH-1:1]};
                end
                MODE_LEFT: begin
                    q_d = {q_q[WIDTH-2:0], bus.serial_in_l};
                end
                MODE_LOAD: begin
                    q_d   = bus.parallel_in;
                    cnt_d = '0;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
            // Both shift directions count toward the same word.
            if (bus.mode == MODE_RIGHT || bus.mode == MODE_LEFT) begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.parallel_out = q_q;
    assign bus.serial_out_r = q_q[0];
    assign bus.serial_out_l = q_q[WIDTH-1];
    assign bus.shift_cnt    = cnt_q;
    assign bus.word_done    = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Purpose: self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): directed
//          scenarios followed by random operations, compared against an arithmetic model.
// Ports:   none (top-level bench).
module tb_univ_shift_reg;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference model: register value as an integer, shifts counted modulo W.
    int   m_q;
    int   m_cnt;
    bit   m_done;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then advance the model with the spec's rules.
    task automatic step(input bit r, input bit e, input bit [1:0] m,
                        input bit [7:0] p, input bit sr, input bit sl);
        @(negedge clk);
        rst             = r;
        bus.en          = e;
        bus.mode        = m;
        bus.parallel_in = p;
        bus.serial_in_r = sr;
        bus.serial_in_l = sl;
        @(posedge clk);
        if (r) begin
            m_q = 0; m_cnt = 0; m_done = 0;
        end else if (!e) begin
            m_done = 0;
        end else begin
            m_done = 0;
            case (m)
                2'd0: ;
                2'd1: m_q = m_q / 2 + int'(sr) * 128;
                2'd2: m_q = (m_q * 2 + int'(sl)) % 256;
                2'd3: begin m_q = int'(p); m_cnt = 0; end
            endcase
            if (m == 2'd1 || m == 2'd2) begin
                m_cnt  = (m_cnt + 1) % W;
                m_done = (m_cnt == 0);
            end
        end
        #1;
    endtask

    task automatic verify(input string tag);
        chk({tag, ".q"},    32'(bus.parallel_out), 32'(m_q));
        chk({tag, ".sor"},  32'(bus.serial_out_r), 32'(m_q % 2));
        chk({tag, ".sol"},  32'(bus.serial_out_l), 32'(m_q / 128));
        chk({tag, ".cnt"},  32'(bus.shift_cnt),    32'(m_cnt));
        chk({tag, ".done"}, 32'(bus.word_done),    32'(m_done));
    endtask

    initial begin
        logic [7:0] ser_exp;
        logic [7:0] des_bits;
        checks = 0; errors = 0;
        m_q = 0; m_cnt = 0; m_done = 0;
        rst = 1'b1;
        bus.en = 1'b0; bus.mode = 2'b00; bus.parallel_in = '0;
        bus.serial_in_r = 1'b0; bus.serial_in_l = 1'b0;

        // 1. Reset beats parallel load.
        step(1, 1, 2'd3, 8'hA5, 0, 0);
        chk("reset.q", 32'(bus.parallel_out), 32'h00);
        chk("reset.cnt", 32'(bus.shift_cnt), 32'd0);
        chk("reset.done", 32'(bus.word_done), 32'd0);
        verify("reset");

        // 2. Serialize 0xA5 LSB-first.
        ser_exp = 8'b1010_0101;
        step(0, 1, 2'd3, 8'hA5, 0, 0);
        chk("ser.bit0", 32'(bus.serial_out_r), 32'(ser_exp[0]));
        verify("ser.load");
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 2'd1, 8'h00, 0, 0);
            if (i < 8) chk("ser.bit", 32'(bus.serial_out_r), 32'(ser_exp[i]));
            verify("ser.shift");
        end
        chk("ser.final_q", 32'(bus.parallel_out), 32'h00);
        chk("ser.final_done", 32'(bus.word_done), 32'd1);
        step(0, 1, 2'd0, 8'h00, 0, 0);
        chk("ser.done_clear", 32'(bus.word_done), 32'd0);
        verify("ser.after");

        // 3. Deserialize into 0xD3 MSB-first.
        des_bits = 8'b1101_0011;
        for (int i = 7; i >= 0; i--) begin
            step(0, 1, 2'd2, 8'h00, 0, des_bits[i]);
            verify("deser");
        end
        chk("deser.q", 32'(bus.parallel_out), 32'hD3);
        chk("deser.done", 32'(bus.word_done), 32'd1);

        // 4. Enable stall mid-word.
        step(0, 1, 2'd3, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 2'd1, 8'h00, 0, 0);
        chk("stall.q", 32'(bus.parallel_out), 32'h07);
        chk("stall.cnt", 32'(bus.shift_cnt), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 2'd1, 8'hFF, 1, 1);
            verify("stall.frozen");
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 2'd1, 8'h00, 1, 0);
            verify("stall.resume");
        end
        chk("stall.done", 32'(bus.word_done), 32'd1);

        // 5. Load and hold mid-word.
        for (int i = 0; i < 5; i++) step(0, 1, 2'd2, 8'h00, 0, 1);
        chk("ldhold.cnt5", 32'(bus.shift_cnt), 32'd5);
        step(0, 1, 2'd3, 8'hF0, 0, 0);
        chk("ldhold.q", 32'(bus.parallel_out), 32'hF0);
        verify("ldhold.load");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'd0, 8'h55, 1, 1);
            verify("ldhold.hold");
        end

        // 6. Reset mid-word, then mixed-direction word.
        for (int i = 0; i < 6; i++) step(0, 1, 2'd1, 8'h00, 1, 0);
        step(1, 1, 2'd1, 8'h00, 1, 1);
        verify("midrst");
        for (int i = 0; i < 8; i++) begin
            step(0, 1, (i < 4) ? 2'd1 : 2'd2, 8'h00, 1, 1);
            verify("mixed");
        end
        chk("mixed.done", 32'(bus.word_done), 32'd1);

        // Random operations.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0,
                 2'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom), 1'($urandom));
            verify("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
